bus_dev_endpoint: RTL

Device-side endpoint for one port of the `bs_gnrtr_n_rbtr` bus: the block the bus pops packets from and pushes packets into. It holds a TX queue that local logic fills and the bus drains through `pndng`/`pop`/`D_pop`. It holds an RX queue that the bus fills through `push`/`D_push` and local logic drains. One instance sits on each of the `drvrs` bus ports, replacing the behavioural driver/monitor model with synthesizable RTL.

---
 rtl/bus_pkg.sv | 13 +
 rtl/ep_fifo.sv | 62 ++++++
 rtl/bus_dev_endpoint.sv | 78 +++++++
 3 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and helpers for the bus device endpoint
package bus_pkg;

    typedef logic [7:0] port_id_t;

    localparam port_id_t BCAST_ID = 8'hFF;

    // Packets up to 64 bits wide are passed zero-extended along with their real width.
    function automatic port_id_t dest_of(input logic [63:0] pkt, input int unsigned sz);
        return port_id_t'(pkt >> (sz - 8));
    endfunction

endpackage

// File: rtl/ep_fifo.sv
// rtl/ep_fifo.sv - synchronous show-ahead FIFO with full-with-read acceptance
module ep_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] din,
    input  logic             rd,
    output logic [width-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_nxt;
    logic             do_rd;
    logic             do_wr;

    // A read frees the head slot in the same cycle, so a write while full still fits.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_comb begin
        cnt_nxt = cnt;
        case ({do_wr, do_rd})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end

    assign dout = empty ? '0 : mem[rptr];

endmodule

// File: rtl/bus_dev_endpoint.sv
// rtl/bus_dev_endpoint.sv - bus port endpoint: TX/RX queues, destination filter, drop counters
module bus_dev_endpoint
    import bus_pkg::*;
#(
    parameter int       pckg_sz   = 16,
    parameter int       depth     = 8,
    parameter port_id_t id        = 8'h00,
    parameter port_id_t broadcast = BCAST_ID
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_pndng,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd,
    output logic [7:0]         rx_ovf_cnt,
    output logic [7:0]         misroute_cnt
);

    logic     tx_empty;
    logic     rx_empty;
    logic     rx_full;
    port_id_t dest;
    logic     match;
    logic     rx_wr;
    logic     ovf_hit;
    logic     mis_hit;

    assign dest    = dest_of(64'(D_push), pckg_sz);
    assign match   = (dest == id) || (dest == broadcast);
    assign rx_wr   = push && match;
    // Misroute wins over overflow; a same-cycle rx_rd makes room in a full queue.
    assign mis_hit = push && !match;
    assign ovf_hit = rx_wr && rx_full && !rx_rd;

    ep_fifo #(.width(pckg_sz), .depth(depth)) tx_q (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .din   (tx_data),
        .rd    (pop),
        .dout  (D_pop),
        .empty (tx_empty),
        .full  (tx_full)
    );

    ep_fifo #(.width(pckg_sz), .depth(depth)) rx_q (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .din   (D_push),
        .rd    (rx_rd),
        .dout  (rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign pndng    = !tx_empty;
    assign rx_pndng = !rx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ovf_cnt   <= '0;
            misroute_cnt <= '0;
        end else begin
            if (ovf_hit && rx_ovf_cnt != 8'hFF)   rx_ovf_cnt   <= rx_ovf_cnt + 1'b1;
            if (mis_hit && misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 1'b1;
        end
    end

endmodule
